// File: rtl/intr_pkg.sv
// Shared defaults and state encoding for the interrupt controller.
// Parameter defaults live here so the top and the bench agree on them.
package intr_pkg;

  localparam int NSRC_DEF = 4;
  localparam int CW_DEF   = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } intr_state_e;

endpackage

// File: rtl/intr_sync_edge.sv
// Per-source 2-flop synchronizer followed by a third flop for rising-edge detect.
// The rise strobe is high for exactly one cycle per low-to-high transition of src.
module intr_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic src,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic sync3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= src;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise = sync2 & ~sync3;

endmodule

// File: rtl/intr_ctrl.sv
// Edge-latched interrupt controller: pending/mask registers, lowest-index
// priority encoder and a non-nesting request/service state machine.
//
// state   | meaning
// IDLE    | no enabled source pending, no handler active
// REQ     | irq raised for the lowest enabled pending source
// SERVICE | handler running with the latched cause, waiting for eret
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int NSRC = NSRC_DEF,
  parameter int CW   = CW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src,
  input  logic            mask_we,
  input  logic [NSRC-1:0] mask_wdata,
  input  logic            int_ack,
  input  logic            eret,
  output logic            irq,
  output logic [CW-1:0]   irq_cause,
  output logic [NSRC-1:0] pending,
  output logic            in_service
);

  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] mask_q;
  logic [NSRC-1:0] pending_q;
  logic [NSRC-1:0] pending_d;
  logic [NSRC-1:0] active;
  logic [NSRC-1:0] clr;
  logic [CW-1:0]   enc;
  logic [CW-1:0]   cause_q;
  logic [CW-1:0]   cause_d;
  logic            any;
  intr_state_e     state_q;
  intr_state_e     state_d;

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    intr_sync_edge u_sync (
      .clk  (clk),
      .rst  (rst),
      .src  (src[g]),
      .rise (rise[g])
    );
  end

  assign active = pending_q & mask_q;
  assign any    = |active;

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    enc = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (active[i]) enc = CW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    clr     = '0;
    case (state_q)
      IDLE: begin
        if (any) state_d = REQ;
      end
      REQ: begin
        if (!any) begin
          state_d = IDLE;
        end else if (int_ack) begin
          state_d = SERVICE;
          cause_d = enc;
          clr     = NSRC'(1) << enc;
        end
      end
      SERVICE: begin
        if (eret) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A new edge on the source being acknowledged keeps it pending.
  assign pending_d = (pending_q & ~clr) | rise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cause_q   <= '0;
      pending_q <= '0;
      mask_q    <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      pending_q <= pending_d;
      if (mask_we) mask_q <= mask_wdata;
    end
  end

  assign irq        = (state_q == REQ);
  assign in_service = (state_q == SERVICE);
  assign irq_cause  = in_service ? cause_q : enc;
  assign pending    = pending_q;

endmodule
